machine_timer: RTL

//  RISC-V machine-timer peripheral (mtime/mtimecmp) and source of the core's timer interrupt.

---
 rtl/timer_pkg.sv | 31 +++
 rtl/machine_timer_if.sv | 17 +
 rtl/timer_prescaler.sv | 44 ++++
 rtl/machine_timer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL bit
// positions, the CTRL register layout and a helper that packs CTRL into
// its 32-bit read-back word.
package timer_pkg;

    localparam int CTRL_PRESC_W = 8;

    localparam logic [7:0] OFS_MTIME_LO    = 8'h00;
    localparam logic [7:0] OFS_MTIME_HI    = 8'h04;
    localparam logic [7:0] OFS_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] OFS_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] OFS_CTRL        = 8'h10;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PRESC_LSB = 8;

    typedef struct packed {
        logic [CTRL_PRESC_W-1:0] prescale;
        logic                    en;
    } ctrl_t;

    // Place the CTRL fields at their bit positions; unused bits read 0.
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[CTRL_EN_BIT] = c.en;
        w[CTRL_PRESC_LSB +: CTRL_PRESC_W] = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/machine_timer_if.sv
// Register-port bundle of the machine timer.
//   req/we/addr/wdata : request from software side (master drives)
//   rdata/ack/err     : registered response, one cycle after req (slave drives)
interface machine_timer_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;
    logic              err;

    modport master (output req, we, addr, wdata, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler for mtime: issues one tick every prescale+1 cycles while en = 1.
//   clk, rst_n : clock, async active-low reset
//   en         : counting enable; 0 clears the counter
//   prescale   : terminal count
//   tick       : one-cycle increment strobe for mtime
module timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt_q;
    logic [PRESC_W-1:0] presc_cnt_d;

    // Next count and tick; >= keeps the counter from running away if prescale is lowered mid-count.
    always_comb begin
        tick        = 1'b0;
        presc_cnt_d = {PRESC_W{1'b0}};
        if (en) begin
            if (presc_cnt_q >= prescale) begin
                tick        = 1'b1;
                presc_cnt_d = {PRESC_W{1'b0}};
            end else begin
                presc_cnt_d = presc_cnt_q + PRESC_W'(1);
            end
        end else begin
            presc_cnt_d = {PRESC_W{1'b0}};
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= {PRESC_W{1'b0}};
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and
// the level timer interrupt feeding mip.MTIP.
//   clk, rst_n : clock, async active-low reset
//   bus        : 32-bit single-outstanding register port (slave side)
//   timer_irq  : registered, 1 while en = 1 and mtime >= mtimecmp
// A MTIME_LO read snapshots mtime[63:32] into hi_shadow so the following
// MTIME_HI read returns a value coherent with the low half.
module machine_timer
    import timer_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          PRESC_W   = CTRL_PRESC_W,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    machine_timer_if.slave        bus,
    output logic                  timer_irq
);

    localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(OFS_MTIME_LO);
    localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(OFS_MTIME_HI);
    localparam logic [ADDR_W-1:0] A_CMP_LO   = ADDR_W'(OFS_MTIMECMP_LO);
    localparam logic [ADDR_W-1:0] A_CMP_HI   = ADDR_W'(OFS_MTIMECMP_HI);
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(OFS_CTRL);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        irq_q, irq_d;

    logic              tick_s;
    logic [ADDR_W-1:0] addr_s;
    logic              bad_addr_s;
    logic              wr_s;
    logic              rd_s;

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ctrl_q.en),
        .prescale (ctrl_q.prescale),
        .tick     (tick_s)
    );

    assign addr_s     = bus.addr;
    assign bad_addr_s = (addr_s > A_CTRL) || (addr_s[1:0] != 2'b00);
    assign wr_s       = bus.req && bus.we && !bad_addr_s;
    assign rd_s       = bus.req && !bus.we && !bad_addr_s;

    // Register updates and read mux; a mtime write replaces the tick for that cycle, no carry between halves.
    always_comb begin
        mtime_d     = tick_s ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        ctrl_d      = ctrl_q;
        hi_shadow_d = hi_shadow_q;
        rdata_d     = 32'h0000_0000;
        if (wr_s) begin
            case (addr_s)
                A_MTIME_LO: mtime_d = {mtime_q[63:32], bus.wdata};
                A_MTIME_HI: mtime_d = {bus.wdata, mtime_q[31:0]};
                A_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], bus.wdata};
                A_CMP_HI:   mtimecmp_d = {bus.wdata, mtimecmp_q[31:0]};
                A_CTRL: begin
                    ctrl_d.en       = bus.wdata[CTRL_EN_BIT];
                    ctrl_d.prescale = bus.wdata[CTRL_PRESC_LSB +: CTRL_PRESC_W];
                end
                default: ctrl_d = ctrl_q;
            endcase
        end else if (rd_s) begin
            case (addr_s)
                A_MTIME_LO: begin
                    rdata_d     = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                A_MTIME_HI: rdata_d = hi_shadow_q;
                A_CMP_LO:   rdata_d = mtimecmp_q[31:0];
                A_CMP_HI:   rdata_d = mtimecmp_q[63:32];
                A_CTRL:     rdata_d = ctrl_to_word(ctrl_q);
                default:    rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Response flags and the interrupt compare, all captured for a one-cycle registered output.
    always_comb begin
        ack_d = bus.req;
        err_d = bus.req && bad_addr_s;
        irq_d = ctrl_q.en && (mtime_q >= mtimecmp_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q     <= 64'h0;
            mtimecmp_q  <= CMP_RESET;
            ctrl_q      <= ctrl_t'({(CTRL_PRESC_W + 1){1'b0}});
            hi_shadow_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            ctrl_q      <= ctrl_d;
            hi_shadow_q <= hi_shadow_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign timer_irq = irq_q;

endmodule
